// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and small helpers for the pipelined adder.
package pipelined_adder_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

    // Signed overflow of a ripple add: the carries into and out of the sign bit disagree.
    function automatic logic signed_ovf(input logic c_msb, input logic c_out);
        return c_msb ^ c_out;
    endfunction

endpackage

// File: rtl/pipelined_adder_chunk_adder.sv
// One CW-bit slice of the pipelined adder: sum, carry out and carry into the slice MSB.
module chunk_adder #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          c_msb
);

    logic [CW:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    assign sum   = full[CW-1:0];
    assign cout  = full[CW];
    assign c_msb = a[CW-1] ^ b[CW-1] ^ sum[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder/subtractor with valid/ready handshake and optional signed saturation.
import pipelined_adder_pkg::*;

module pipelined_adder #(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int STAGES   = DEF_STAGES,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             overflow
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: illegal WIDTH/STAGES combination");
    end

    // Per-stage pipeline registers: skewed operands, deskewed sum, chunk carry, valid.
    logic [WIDTH-1:0] a_r [STAGES];
    logic [WIDTH-1:0] b_r [STAGES];
    logic [WIDTH-1:0] s_r [STAGES];
    logic             c_r [STAGES];
    logic             v_r [STAGES];
    logic             ovf_r;

    logic [CW-1:0]    ca [STAGES];
    logic [CW-1:0]    cb [STAGES];
    logic [CW-1:0]    cs [STAGES];
    logic             ci [STAGES];
    logic             co [STAGES];
    logic             cm [STAGES];
    logic [WIDTH-1:0] s_prev [STAGES];
    logic [WIDTH-1:0] s_nxt  [STAGES];
    logic             ovf_nxt;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             stall;

    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
    assign stall   = v_r[LAST] && !out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign ca[k]     = a[CW-1:0];
            assign cb[k]     = b_eff[CW-1:0];
            assign ci[k]     = cin_eff;
            assign s_prev[k] = '0;
        end else begin : g_rest
            assign ca[k]     = a_r[k-1][k*CW +: CW];
            assign cb[k]     = b_r[k-1][k*CW +: CW];
            assign ci[k]     = c_r[k-1];
            assign s_prev[k] = s_r[k-1];
        end

        chunk_adder #(.CW(CW)) u_chunk (
            .a     (ca[k]),
            .b     (cb[k]),
            .cin   (ci[k]),
            .sum   (cs[k]),
            .cout  (co[k]),
            .c_msb (cm[k])
        );
    end

    // The last stage folds in saturation; a[MSB] is still an untouched operand chunk there.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_nxt[k] = s_prev[k];
            s_nxt[k][k*CW +: CW] = cs[k];
        end
        ovf_nxt = signed_ovf(cm[LAST], co[LAST]);
        if (SATURATE != 0 && ovf_nxt) begin
            s_nxt[LAST] = ca[LAST][CW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k] <= 1'b0;
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
                c_r[k] <= 1'b0;
            end
            ovf_r <= 1'b0;
        end else if (!stall) begin
            v_r[0] <= in_valid;
            a_r[0] <= a;
            b_r[0] <= b_eff;
            for (int k = 1; k < STAGES; k++) begin
                v_r[k] <= v_r[k-1];
                a_r[k] <= a_r[k-1];
                b_r[k] <= b_r[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                s_r[k] <= s_nxt[k];
                c_r[k] <= co[k];
            end
            ovf_r <= ovf_nxt;
        end
    end

    assign in_ready  = !stall;
    assign out_valid = v_r[LAST];
    assign s         = s_r[LAST];
    assign cout      = c_r[LAST];
    assign overflow  = ovf_r;

endmodule
